// File: rtl/commit_write_queue_if.sv
// rtl/commit_write_queue_if.sv - commit capture and head-drain signal bundle for commit_write_queue
interface commit_write_queue_if #(
   parameter int KEY_WIDTH   = 64,
   parameter int VALUE_WIDTH = 128,
   parameter int DEPTH       = 16,
   parameter int STEP_WIDTH  = 16
);
   logic                       commit_i;
   logic                       we1_i;
   logic [KEY_WIDTH-1:0]       wa1_i;
   logic [VALUE_WIDTH-1:0]     wd1_i;
   logic                       we2_i;
   logic [KEY_WIDTH-1:0]       wa2_i;
   logic [VALUE_WIDTH-1:0]     wd2_i;
   logic                       flush_i;
   logic                       out_valid_o;
   logic                       out_ready_i;
   logic [KEY_WIDTH-1:0]       out_key_o;
   logic [VALUE_WIDTH-1:0]     out_value_o;
   logic [STEP_WIDTH-1:0]      out_step_o;
   logic [$clog2(DEPTH):0]     count_o;
   logic                       full_o;
   logic                       overflow_o;

   modport slave (
      input  commit_i, we1_i, wa1_i, wd1_i, we2_i, wa2_i, wd2_i, flush_i, out_ready_i,
      output out_valid_o, out_key_o, out_value_o, out_step_o, count_o, full_o, overflow_o
   );

   modport master (
      output commit_i, we1_i, wa1_i, wd1_i, we2_i, wa2_i, wd2_i, flush_i, out_ready_i,
      input  out_valid_o, out_key_o, out_value_o, out_step_o, count_o, full_o, overflow_o
   );
endinterface

// File: rtl/commit_write_queue.sv
// rtl/commit_write_queue.sv - ordered, same-step-coalescing FIFO of register-write commits
module commit_write_queue #(
   parameter int KEY_WIDTH   = 64,
   parameter int VALUE_WIDTH = 128,
   parameter int DEPTH       = 16,
   parameter int STEP_WIDTH  = 16
) (
   input logic                 clk_i,
   input logic                 rst_i,
   commit_write_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [KEY_WIDTH-1:0]   key_mem_q   [DEPTH];
   logic [VALUE_WIDTH-1:0] value_mem_q [DEPTH];
   logic [STEP_WIDTH-1:0]  step_mem_q  [DEPTH];

   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_next;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [STEP_WIDTH-1:0] step_q, step_d;
   logic                  overflow_q, overflow_d;

   logic                   same_key;
   logic [1:0]             needed;
   logic [CNT_W-1:0]       free_slots;
   logic                   drop;
   logic                   accept;
   logic                   pop;
   logic [CNT_W-1:0]       push_cnt;
   logic                   wr0_en, wr1_en;
   logic [KEY_WIDTH-1:0]   e0_key;
   logic [VALUE_WIDTH-1:0] e0_value;

   // Build the push set for this commit, check space against registered count, and compute next state
   always_comb begin
      same_key    = bus.we1_i && bus.we2_i && (bus.wa1_i == bus.wa2_i);
      needed      = 2'd0;
      e0_key      = bus.wa2_i;
      e0_value    = bus.wd2_i;
      wr0_en      = 1'b0;
      wr1_en      = 1'b0;
      push_cnt    = '0;
      wr_ptr_next = wr_ptr_q + PTR_W'(1);

      // Port 1 leads unless port 2 overwrites the same key within the step
      if (bus.we1_i && !same_key) begin
         e0_key   = bus.wa1_i;
         e0_value = bus.wd1_i;
      end
      if (bus.commit_i) begin
         if (bus.we1_i && bus.we2_i && !same_key) needed = 2'd2;
         else if (bus.we1_i || bus.we2_i)        needed = 2'd1;
      end

      // Free space ignores a same-cycle pop so the accept decision never depends on the consumer
      free_slots = CNT_W'(DEPTH) - count_q;
      drop       = bus.commit_i && ({{(CNT_W-2){1'b0}}, needed} > free_slots);
      accept     = bus.commit_i && !drop && !bus.flush_i;
      pop        = (count_q != '0) && bus.out_ready_i && !bus.flush_i;

      if (accept) begin
         wr0_en   = (needed != 2'd0);
         wr1_en   = (needed == 2'd2);
         push_cnt = {{(CNT_W-2){1'b0}}, needed};
      end

      // Tags count every commit pulse so they stay aligned with the reference step count
      step_d = bus.commit_i ? step_q + STEP_WIDTH'(1) : step_q;

      if (bus.flush_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
         wr_ptr_d   = wr_ptr_q + push_cnt[PTR_W-1:0];
         count_d    = count_q + push_cnt - {{(CNT_W-1){1'b0}}, pop};
         overflow_d = overflow_q | drop;
      end
   end

   // Control state and entry storage; storage is cleared on reset so the idle head reads zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         step_q     <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            key_mem_q[i]   <= '0;
            value_mem_q[i] <= '0;
            step_mem_q[i]  <= '0;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         step_q     <= step_d;
         overflow_q <= overflow_d;
         if (wr0_en) begin
            key_mem_q[wr_ptr_q]   <= e0_key;
            value_mem_q[wr_ptr_q] <= e0_value;
            step_mem_q[wr_ptr_q]  <= step_q;
         end
         if (wr1_en) begin
            key_mem_q[wr_ptr_next]   <= bus.wa2_i;
            value_mem_q[wr_ptr_next] <= bus.wd2_i;
            step_mem_q[wr_ptr_next]  <= step_q;
         end
      end
   end

   assign bus.out_valid_o = (count_q != '0);
   assign bus.out_key_o   = key_mem_q[rd_ptr_q];
   assign bus.out_value_o = value_mem_q[rd_ptr_q];
   assign bus.out_step_o  = step_mem_q[rd_ptr_q];
   assign bus.count_o     = count_q;
   assign bus.full_o      = (count_q == CNT_W'(DEPTH));
   assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_commit_write_queue.sv
// tb/tb_commit_write_queue.sv - directed vector bench for commit_write_queue
module tb_commit_write_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   commit_write_queue_if bus ();

   commit_write_queue dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         commit;
      logic         we1;
      logic [63:0]  wa1;
      logic [127:0] wd1;
      logic         we2;
      logic [63:0]  wa2;
      logic [127:0] wd2;
      logic         flush;
      logic         ready;
      logic         chk_data;
      logic         exp_valid;
      logic [63:0]  exp_key;
      logic [127:0] exp_value;
      logic [15:0]  exp_step;
      logic [4:0]   exp_count;
      logic         exp_full;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [4:0] cnt,
                            input logic full, input logic ovf);
      chk({tag, ".valid"}, 128'(bus.out_valid_o), 128'(v));
      chk({tag, ".count"}, 128'(bus.count_o), 128'(cnt));
      chk({tag, ".full"}, 128'(bus.full_o), 128'(full));
      chk({tag, ".overflow"}, 128'(bus.overflow_o), 128'(ovf));
   endtask

   task automatic chk_head(input string tag, input logic [63:0] key, input logic [127:0] val,
                           input logic [15:0] step);
      chk({tag, ".key"}, 128'(bus.out_key_o), 128'(key));
      chk({tag, ".value"}, bus.out_value_o, val);
      chk({tag, ".step"}, 128'(bus.out_step_o), 128'(step));
   endtask

   task automatic drive(input logic commit, input logic we1, input logic [63:0] wa1,
                        input logic [127:0] wd1, input logic we2, input logic [63:0] wa2,
                        input logic [127:0] wd2, input logic flush, input logic ready);
      bus.commit_i    = commit;
      bus.we1_i       = we1;
      bus.wa1_i       = wa1;
      bus.wd1_i       = wd1;
      bus.we2_i       = we2;
      bus.wa2_i       = wa2;
      bus.wd2_i       = wd2;
      bus.flush_i     = flush;
      bus.out_ready_i = ready;
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [63:0] key, input logic [127:0] val, input logic ready);
      drive(1'b1, 1'b1, key, val, 1'b0, 64'd0, 128'd0, 1'b0, ready);
   endtask

   task automatic idle(input logic ready);
      drive(1'b0, 1'b0, 64'd0, 128'd0, 1'b0, 64'd0, 128'd0, 1'b0, ready);
   endtask

   initial begin
      // commit we1 wa1 wd1 we2 wa2 wd2 flush ready | chk valid key value step count full ovf
      vecs[0] = '{1, 1, 5, 'hA, 0, 0, 0, 0, 0,     1, 1, 5, 'hA, 0, 1, 0, 0};
      vecs[1] = '{1, 1, 7, 1, 1, 7, 2, 0, 0,       1, 1, 5, 'hA, 0, 2, 0, 0};
      vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,       1, 1, 7, 2, 1, 1, 0, 0};
      vecs[3] = '{1, 1, 3, 'h33, 1, 4, 'h44, 0, 0, 1, 1, 7, 2, 1, 3, 0, 0};
      vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,       1, 1, 3, 'h33, 2, 2, 0, 0};
      vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,       1, 1, 4, 'h44, 2, 1, 0, 0};
      vecs[6] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 1, 4, 'h44, 2, 1, 0, 0};
      vecs[7] = '{1, 0, 0, 0, 1, 9, 'h99, 0, 1,    1, 1, 9, 'h99, 4, 1, 0, 0};
      vecs[8] = '{0, 1, 'hE, 'hE, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0};
      vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 0, 0, 0, 0, 0};

      bus.commit_i = 0; bus.we1_i = 0; bus.wa1_i = '0; bus.wd1_i = '0;
      bus.we2_i = 0; bus.wa2_i = '0; bus.wd2_i = '0; bus.flush_i = 0; bus.out_ready_i = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_state("reset", 0, 0, 0, 0);
      chk_head("reset", 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].commit, vecs[i].we1, vecs[i].wa1, vecs[i].wd1, vecs[i].we2,
               vecs[i].wa2, vecs[i].wd2, vecs[i].flush, vecs[i].ready);
         chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count,
                   vecs[i].exp_full, vecs[i].exp_ovf);
         if (vecs[i].chk_data)
            chk_head($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_value, vecs[i].exp_step);
      end

      // fill to DEPTH-1, then a two-write commit must be dropped whole (step counter now 5)
      for (int i = 0; i < 15; i++) single(64'(100 + i), 128'(1000 + i), 1'b0);
      chk_state("fill15", 1, 15, 0, 0);
      chk_head("fill15", 100, 1000, 5);
      drive(1'b1, 1'b1, 64'd300, 128'd1, 1'b1, 64'd301, 128'd2, 1'b0, 1'b0);
      chk_state("drop_pair", 1, 15, 0, 1);
      single(64'd200, 128'd2000, 1'b0);
      chk_state("fill16", 1, 16, 1, 1);

      // full queue, pop and single commit in one cycle: no pop credit, commit dropped
      single(64'd400, 128'd4000, 1'b1);
      chk_state("full_pop_push", 1, 15, 0, 1);

      for (int i = 1; i < 15; i++) begin
         chk_head($sformatf("drain%0d", i), 64'(100 + i), 128'(1000 + i), 16'(5 + i));
         idle(1'b1);
      end
      chk_head("drain_last", 200, 2000, 21);
      chk_state("drain_last", 1, 1, 0, 1);
      idle(1'b1);
      chk_state("drained", 0, 0, 0, 1);

      // nine entries, then flush with a same-cycle commit and pop (step counter now 23)
      for (int i = 0; i < 9; i++) single(64'(500 + i), 128'(5000 + i), 1'b0);
      chk_state("fill9", 1, 9, 0, 1);
      chk_head("fill9", 500, 5000, 23);
      drive(1'b1, 1'b1, 64'd600, 128'd6000, 1'b0, 64'd0, 128'd0, 1'b1, 1'b1);
      chk_state("flush", 0, 0, 0, 0);
      single(64'd601, 128'd6010, 1'b0);
      chk_state("post_flush", 1, 1, 0, 0);
      chk_head("post_flush", 601, 6010, 33);

      // asynchronous reset in mid-cycle clears state before the next edge
      single(64'd602, 128'd6020, 1'b0);
      #2 rst = 1'b1;
      #1 chk_state("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      single(64'd700, 128'd7000, 1'b0);
      chk_state("after_rst", 1, 1, 0, 0);
      chk_head("after_rst", 700, 7000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
